// File: rtl/one_to_two_demux.sv
// One-input, two-output demultiplexer: each input word is steered by select into
// a per-port FIFO, and each port drains independently with valid/ready handshakes.
module one_to_two_demux #(
    parameter int BIT_WIDTH = 32,
    parameter int DEPTH     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     select,
    input  logic [BIT_WIDTH-1:0]     dataIn,
    output logic                     out0_valid,
    output logic                     out1_valid,
    input  logic                     out0_ready,
    input  logic                     out1_ready,
    output logic [BIT_WIDTH-1:0]     dataOut0,
    output logic [BIT_WIDTH-1:0]     dataOut1,
    output logic [15:0]              count0,
    output logic [15:0]              count1,
    output logic [$clog2(DEPTH):0]   level0,
    output logic [$clog2(DEPTH):0]   level1
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [1:0]           q_full;
    logic [1:0]           q_valid;
    logic [1:0]           q_push;
    logic [1:0]           q_pop;
    logic [1:0]           q_ready;
    logic [BIT_WIDTH-1:0] q_head  [2];
    logic [LW-1:0]        q_level [2];
    logic [15:0]          q_count [2];

    assign q_ready = {out1_ready, out0_ready};

    // Fullness is judged on the pre-pop level, so a full queue never accepts a
    // word in the same cycle it is being drained.
    assign in_ready = !reset && !(select ? q_full[1] : q_full[0]);

    for (genvar p = 0; p < 2; p++) begin : g_q
        localparam logic SEL = 1'(p);

        logic [BIT_WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]        wr_ptr;
        logic [PW-1:0]        rd_ptr;
        logic [LW-1:0]        level;
        logic [15:0]          count;

        assign q_full[p]  = (level == LW'(DEPTH));
        assign q_valid[p] = (level != '0);
        assign q_push[p]  = in_valid && in_ready && (select == SEL);
        assign q_pop[p]   = q_valid[p] && q_ready[p];
        assign q_head[p]  = q_valid[p] ? mem[rd_ptr] : '0;
        assign q_level[p] = level;
        assign q_count[p] = count;

        always_ff @(posedge clk) begin
            if (q_push[p]) begin
                mem[wr_ptr] <= dataIn;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
                count  <= '0;
            end else begin
                if (q_push[p]) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (q_pop[p]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    count  <= count + 16'd1;
                end
                if (q_push[p] && !q_pop[p]) begin
                    level <= level + 1'b1;
                end else if (!q_push[p] && q_pop[p]) begin
                    level <= level - 1'b1;
                end
            end
        end
    end

    assign out0_valid = q_valid[0];
    assign out1_valid = q_valid[1];
    assign dataOut0   = q_head[0];
    assign dataOut1   = q_head[1];
    assign count0     = q_count[0];
    assign count1     = q_count[1];
    assign level0     = q_level[0];
    assign level1     = q_level[1];

endmodule

// File: tb/tb_one_to_two_demux.sv
// Bench for one_to_two_demux: a queue-based reference model checks every cycle,
// and directed scenario tasks check the specific sequences.
module tb_one_to_two_demux;

    localparam int BW    = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            select = 1'b0;
    logic [BW-1:0]   dataIn = '0;
    logic            out0_valid, out1_valid;
    logic            out0_ready = 1'b0;
    logic            out1_ready = 1'b0;
    logic [BW-1:0]   dataOut0, dataOut1;
    logic [15:0]     count0, count1;
    logic [1:0]      level0, level1;

    int checks = 0;
    int passes = 0;
    bit mon_en = 1'b0;

    logic [BW-1:0] sb0 [$];
    logic [BW-1:0] sb1 [$];
    logic [15:0]   m_cnt0 = '0;
    logic [15:0]   m_cnt1 = '0;

    always #5 clk = ~clk;

    one_to_two_demux #(.BIT_WIDTH(BW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .select     (select),
        .dataIn     (dataIn),
        .out0_valid (out0_valid),
        .out1_valid (out1_valid),
        .out0_ready (out0_ready),
        .out1_ready (out1_ready),
        .dataOut0   (dataOut0),
        .dataOut1   (dataOut1),
        .count0     (count0),
        .count1     (count1),
        .level0     (level0),
        .level1     (level1)
    );

    // Reference model: sampled mid-cycle, predicts the transfers at the next edge.
    always @(negedge clk) begin
        logic          exp_rdy;
        logic [BW-1:0] e0, e1;
        if (mon_en) begin
            exp_rdy = !reset && (select ? (sb1.size() < DEPTH) : (sb0.size() < DEPTH));
            e0 = (sb0.size() > 0) ? sb0[0] : '0;
            e1 = (sb1.size() > 0) ? sb1[0] : '0;

            checks++;
            if (in_ready !== exp_rdy) $display("FAIL mon_in_ready got %b exp %b t=%0t", in_ready, exp_rdy, $time);
            else passes++;
            checks++;
            if (out0_valid !== (sb0.size() != 0)) $display("FAIL mon_out0_valid got %b exp %b t=%0t", out0_valid, sb0.size() != 0, $time);
            else passes++;
            checks++;
            if (out1_valid !== (sb1.size() != 0)) $display("FAIL mon_out1_valid got %b exp %b t=%0t", out1_valid, sb1.size() != 0, $time);
            else passes++;
            checks++;
            if (dataOut0 !== e0) $display("FAIL mon_data0 got %h exp %h t=%0t", dataOut0, e0, $time);
            else passes++;
            checks++;
            if (dataOut1 !== e1) $display("FAIL mon_data1 got %h exp %h t=%0t", dataOut1, e1, $time);
            else passes++;
            checks++;
            if (level0 !== 2'(sb0.size()) || level1 !== 2'(sb1.size()))
                $display("FAIL mon_level got %0d/%0d exp %0d/%0d t=%0t", level0, level1, sb0.size(), sb1.size(), $time);
            else passes++;
            checks++;
            if (count0 !== m_cnt0 || count1 !== m_cnt1)
                $display("FAIL mon_count got %0d/%0d exp %0d/%0d t=%0t", count0, count1, m_cnt0, m_cnt1, $time);
            else passes++;

            if (reset) begin
                sb0.delete();
                sb1.delete();
                m_cnt0 = '0;
                m_cnt1 = '0;
            end else begin
                if (sb0.size() > 0 && out0_ready) begin
                    void'(sb0.pop_front());
                    m_cnt0 = m_cnt0 + 16'd1;
                end
                if (sb1.size() > 0 && out1_ready) begin
                    void'(sb1.pop_front());
                    m_cnt1 = m_cnt1 + 16'd1;
                end
                if (in_valid && exp_rdy) begin
                    if (select) sb1.push_back(dataIn);
                    else        sb0.push_back(dataIn);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [BW-1:0] d);
        in_valid = v;
        select   = s;
        dataIn   = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 1'b0, 32'h1234);
        out0_ready = 1'b1;
        cyc();
        mon_en = 1'b1;
        cyc();
        checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready);
        else passes++;
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0) $display("FAIL reset_valid got %b%b exp 00", out0_valid, out1_valid);
        else passes++;
        checks++;
        if (dataOut0 !== '0 || dataOut1 !== '0 || level0 !== '0 || level1 !== '0 || count0 !== '0 || count1 !== '0)
            $display("FAIL reset_state got d=%h/%h l=%0d/%0d c=%0d/%0d exp zeros", dataOut0, dataOut1, level0, level1, count0, count1);
        else passes++;
        drive(1'b0, 1'b0, '0);
        out0_ready = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready got %b exp 1", in_ready);
        else passes++;
    endtask

    task automatic test_route();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        drive(1'b1, 1'b0, 32'd2);
        cyc();
        checks++;
        if (out0_valid !== 1'b1 || dataOut0 !== 32'd2) $display("FAIL route_out0 got v=%b d=%0d exp v=1 d=2", out0_valid, dataOut0);
        else passes++;
        drive(1'b1, 1'b1, 32'd4);
        cyc();
        checks++;
        if (out1_valid !== 1'b1 || dataOut1 !== 32'd4) $display("FAIL route_out1 got v=%b d=%0d exp v=1 d=4", out1_valid, dataOut1);
        else passes++;
        checks++;
        if (count0 !== 16'd1 || out0_valid !== 1'b0) $display("FAIL route_count0 got c=%0d v=%b exp c=1 v=0", count0, out0_valid);
        else passes++;
        drive(1'b0, 1'b0, '0);
        cyc();
        checks++;
        if (count1 !== 16'd1 || out1_valid !== 1'b0) $display("FAIL route_count1 got c=%0d v=%b exp c=1 v=0", count1, out1_valid);
        else passes++;
    endtask

    task automatic test_idle();
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'(i), 32'hDEAD_0000 + BW'(i));
            cyc();
        end
        checks++;
        if (level0 !== '0 || level1 !== '0) $display("FAIL idle_level got %0d/%0d exp 0/0", level0, level1);
        else passes++;
    endtask

    task automatic test_fill();
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        drive(1'b1, 1'b0, 32'd10);
        cyc();
        drive(1'b1, 1'b0, 32'd11);
        cyc();
        checks++;
        if (level0 !== 2'd2) $display("FAIL fill_level0 got %0d exp 2", level0);
        else passes++;
        drive(1'b1, 1'b0, 32'd12);
        #1;
        checks++;
        if (in_ready !== 1'b0) $display("FAIL fill_ready_sel0 got %b exp 0", in_ready);
        else passes++;
        drive(1'b1, 1'b1, 32'd20);
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL fill_ready_sel1 got %b exp 1", in_ready);
        else passes++;
        cyc();
        drive(1'b0, 1'b0, '0);
        checks++;
        if (level1 !== 2'd1 || level0 !== 2'd2) $display("FAIL fill_other_port got %0d/%0d exp 2/1", level0, level1);
        else passes++;
    endtask

    task automatic test_drain();
        out0_ready = 1'b1;
        checks++;
        if (dataOut0 !== 32'd10) $display("FAIL drain_first got %0d exp 10", dataOut0);
        else passes++;
        cyc();
        checks++;
        if (dataOut0 !== 32'd11 || level0 !== 2'd1) $display("FAIL drain_second got d=%0d l=%0d exp d=11 l=1", dataOut0, level0);
        else passes++;
        cyc();
        checks++;
        if (level0 !== '0 || out0_valid !== 1'b0 || count0 !== 16'd3) $display("FAIL drain_done got l=%0d v=%b c=%0d exp l=0 v=0 c=3", level0, out0_valid, count0);
        else passes++;
        out1_ready = 1'b1;
        cyc();
        checks++;
        if (count1 !== 16'd2 || level1 !== '0) $display("FAIL drain_port1 got c=%0d l=%0d exp c=2 l=0", count1, level1);
        else passes++;
    endtask

    task automatic test_full_pop();
        out0_ready = 1'b0;
        drive(1'b1, 1'b0, 32'd30);
        cyc();
        drive(1'b1, 1'b0, 32'd31);
        cyc();
        out0_ready = 1'b1;
        drive(1'b1, 1'b0, 32'd32);
        #1;
        checks++;
        if (in_ready !== 1'b0) $display("FAIL fullpop_no_bypass got %b exp 0", in_ready);
        else passes++;
        cyc();
        checks++;
        if (level0 !== 2'd1 || dataOut0 !== 32'd31 || in_ready !== 1'b1)
            $display("FAIL fullpop_after_pop got l=%0d d=%0d r=%b exp l=1 d=31 r=1", level0, dataOut0, in_ready);
        else passes++;
        cyc();
        checks++;
        if (level0 !== 2'd1 || dataOut0 !== 32'd32) $display("FAIL fullpop_push_pop got l=%0d d=%0d exp l=1 d=32", level0, dataOut0);
        else passes++;
        drive(1'b0, 1'b0, '0);
        cyc();
        checks++;
        if (level0 !== '0 || count0 !== 16'd6) $display("FAIL fullpop_end got l=%0d c=%0d exp l=0 c=6", level0, count0);
        else passes++;
    endtask

    task automatic test_back_to_back();
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        drive(1'b1, 1'b0, 32'd50);
        cyc();
        drive(1'b1, 1'b0, 32'd51);
        cyc();
        drive(1'b1, 1'b1, 32'd60);
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL b2b_other_not_blocked got %b exp 1", in_ready);
        else passes++;
        cyc();
        drive(1'b1, 1'b1, 32'd61);
        cyc();
        drive(1'b0, 1'b0, '0);
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        cyc();
        checks++;
        if (count0 !== 16'd7 || count1 !== 16'd3 || dataOut0 !== 32'd51 || dataOut1 !== 32'd61)
            $display("FAIL b2b_dual_pop got c=%0d/%0d d=%0d/%0d exp c=7/3 d=51/61", count0, count1, dataOut0, dataOut1);
        else passes++;
        cyc();
        checks++;
        if (count0 !== 16'd8 || count1 !== 16'd4) $display("FAIL b2b_dual_pop2 got %0d/%0d exp 8/4", count0, count1);
        else passes++;
    endtask

    task automatic test_reset_mid();
        out1_ready = 1'b0;
        drive(1'b1, 1'b1, 32'd70);
        cyc();
        drive(1'b1, 1'b1, 32'd71);
        cyc();
        drive(1'b0, 1'b0, '0);
        checks++;
        if (level1 !== 2'd2) $display("FAIL rstmid_level_before got %0d exp 2", level1);
        else passes++;
        reset = 1'b1;
        out1_ready = 1'b1;
        cyc();
        reset = 1'b0;
        out0_ready = 1'b1;
        #1;
        checks++;
        if (out1_valid !== 1'b0 || level1 !== '0 || count1 !== '0 || count0 !== '0 || dataOut1 !== '0 || in_ready !== 1'b1)
            $display("FAIL rstmid_cleared got v=%b l=%0d c=%0d/%0d d=%h r=%b exp v=0 l=0 c=0/0 d=0 r=1",
                     out1_valid, level1, count0, count1, dataOut1, in_ready);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (out1_valid !== 1'b0 || count1 !== '0) $display("FAIL rstmid_stale got v=%b c=%0d exp v=0 c=0", out1_valid, count1);
            else passes++;
        end
    endtask

    task automatic test_wrap();
        out0_ready = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            drive(1'b1, 1'b0, $urandom);
            cyc();
        end
        checks++;
        if (count0 !== 16'hFFFF) $display("FAIL wrap_before got %0d exp 65535", count0);
        else passes++;
        drive(1'b0, 1'b0, '0);
        cyc();
        checks++;
        if (count0 !== 16'd0 || level0 !== '0) $display("FAIL wrap_after got c=%0d l=%0d exp c=0 l=0", count0, level0);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_route();
        test_idle();
        test_fill();
        test_drain();
        test_full_pop();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        cyc();
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
